mem_wb_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Consumes the EX/MEM latch outputs and drives the data-cache request port.
- Selects write-back data and registers the result for the WB stage.
- Owns the data-hit handshake: issues exactly one request per memory instruction and stalls the pipeline until that request completes.

---
 rtl/mem_wb_stage_if.sv | 24 ++
 rtl/mem_wb_stage.sv | 145 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-cache request port between the memory stage and the data cache.
//   master (pipeline side): drives dmemREN/dmemWEN/dmemaddr/dmemstore,
//                           receives dhit/dmemload.
//   slave  (cache side)   : the mirror image.
interface mem_wb_stage_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register of a 5-stage MIPS pipe.
//   CLK, nRST            : clock, asynchronous active-low reset
//   ihit                 : instruction side ready; pipeline advances only when high
//   *_in                 : EX/MEM latch contents (controls, operands, wsel)
//   dif (master)         : data-cache request port (REN/WEN/addr/store, dhit/load)
//   mem_stall            : freezes the earlier stages while a data access is open
//   RegWr_out/wsel_out/wdat_out/halt_out : registered MEM/WB contents
// Each memory instruction issues exactly one cache request. If the request
// completes while the instruction side is stalled, the load data is parked
// in ldbuf and the FSM sits in DONE (request dropped) until ihit returns.
module mem_wb_stage #(
    parameter int WORD_W = 32,
    parameter int WSEL_W = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              MemtoReg_in,
    input  logic              RegWr_in,
    input  logic              jal_s_in,
    input  logic              lui_in,
    input  logic              halt_in,
    input  logic [WSEL_W-1:0] wsel_in,
    input  logic [WORD_W-1:0] alu_portOut_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic [WORD_W-1:0] pcplusfour_in,
    input  logic [15:0]       imm_addr_in,
    mem_wb_stage_if.master    dif,
    output logic              mem_stall,
    output logic              RegWr_out,
    output logic [WSEL_W-1:0] wsel_out,
    output logic [WORD_W-1:0] wdat_out,
    output logic              halt_out
);

    typedef enum logic {IDLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] ldbuf_q, ldbuf_d;
    logic              regwr_q, regwr_d;
    logic [WSEL_W-1:0] wsel_q, wsel_d;
    logic [WORD_W-1:0] wdat_q, wdat_d;
    logic              halt_q, halt_d;

    logic              memop;
    logic              req_ren;
    logic              req_wen;
    logic              adv;
    logic              sel_load;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] lui_val;
    logic [WORD_W-1:0] wb_val;

    // nRST gates the request so it drops the instant reset is asserted.
    assign memop = (dREN_in | dWEN_in) & ~halt_q & nRST;

    always_comb begin
        state_d   = state_q;
        ldbuf_d   = ldbuf_q;
        req_ren   = 1'b0;
        req_wen   = 1'b0;
        mem_stall = 1'b0;
        load_data = ldbuf_q;
        case (state_q)
            IDLE: begin
                // REN and WEN together decode as a store.
                req_ren   = memop & dREN_in & ~dWEN_in;
                req_wen   = memop & dWEN_in;
                mem_stall = memop & ~dif.dhit;
                load_data = dif.dmemload;
                if (memop & dif.dhit & ~ihit) begin
                    ldbuf_d = dif.dmemload;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ihit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign adv      = ihit & ~mem_stall;
    assign sel_load = MemtoReg_in & ~(dREN_in & dWEN_in);
    assign lui_val  = {imm_addr_in, {(WORD_W-16){1'b0}}};

    always_comb begin
        if (jal_s_in) begin
            wb_val = pcplusfour_in;
        end else if (lui_in) begin
            wb_val = lui_val;
        end else if (sel_load) begin
            wb_val = load_data;
        end else begin
            wb_val = alu_portOut_in;
        end
    end

    // MEM/WB register: holds (no bubble) whenever the pipe does not advance.
    always_comb begin
        regwr_d = regwr_q;
        wsel_d  = wsel_q;
        wdat_d  = wdat_q;
        halt_d  = halt_q;
        if (adv) begin
            regwr_d = RegWr_in & ~halt_q;
            wsel_d  = wsel_in;
            wdat_d  = wb_val;
            halt_d  = halt_q | halt_in;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ldbuf_q <= '0;
            regwr_q <= 1'b0;
            wsel_q  <= '0;
            wdat_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ldbuf_q <= ldbuf_d;
            regwr_q <= regwr_d;
            wsel_q  <= wsel_d;
            wdat_q  <= wdat_d;
            halt_q  <= halt_d;
        end
    end

    assign dif.dmemREN   = req_ren;
    assign dif.dmemWEN   = req_wen;
    assign dif.dmemaddr  = alu_portOut_in;
    assign dif.dmemstore = rdat2_in;

    assign RegWr_out = regwr_q;
    assign wsel_out  = wsel_q;
    assign wdat_out  = wdat_q;
    assign halt_out  = halt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a driver issues instructions against a simple
// "outstanding request / served" model and queues expected per-cycle
// request outputs and expected MEM/WB contents; a monitor pops and compares.
module tb_mem_wb_stage;
    localparam int WORD_W = 32;
    localparam int WSEL_W = 5;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              ihit, dREN_in, dWEN_in, MemtoReg_in, RegWr_in;
    logic              jal_s_in, lui_in, halt_in;
    logic [WSEL_W-1:0] wsel_in;
    logic [WORD_W-1:0] alu_portOut_in, rdat2_in, pcplusfour_in;
    logic [15:0]       imm_addr_in;
    logic              mem_stall, RegWr_out, halt_out;
    logic [WSEL_W-1:0] wsel_out;
    logic [WORD_W-1:0] wdat_out;

    mem_wb_stage_if #(.WORD_W(WORD_W)) dif ();

    mem_wb_stage #(.WORD_W(WORD_W), .WSEL_W(WSEL_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .MemtoReg_in(MemtoReg_in),
        .RegWr_in(RegWr_in), .jal_s_in(jal_s_in), .lui_in(lui_in),
        .halt_in(halt_in), .wsel_in(wsel_in), .alu_portOut_in(alu_portOut_in),
        .rdat2_in(rdat2_in), .pcplusfour_in(pcplusfour_in),
        .imm_addr_in(imm_addr_in), .dif(dif), .mem_stall(mem_stall),
        .RegWr_out(RegWr_out), .wsel_out(wsel_out), .wdat_out(wdat_out),
        .halt_out(halt_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen, stall, adv;
        logic [31:0] addr, store;
    } ctl_t;

    typedef struct {
        logic        regwr;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic        halt;
    } wb_t;

    typedef struct {
        logic        ren, wen, m2r, rw, jal, lui, halt;
        logic [4:0]  wsel;
        logic [31:0] alu, rdat2, pc4;
        logic [15:0] imm;
    } ins_t;

    ctl_t ctl_q[$];
    wb_t  wb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic m_halt = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ihit = 0; dREN_in = 0; dWEN_in = 0; MemtoReg_in = 0; RegWr_in = 0;
        jal_s_in = 0; lui_in = 0; halt_in = 0; wsel_in = '0;
        alu_portOut_in = '0; rdat2_in = '0; pcplusfour_in = '0; imm_addr_in = '0;
        dif.dhit = 0; dif.dmemload = '0;
    endtask

    // Holds one instruction in the stage until it advances. The cache answers
    // on cycle dhit_at; ihit follows ihit_mask, forced high from cycle 8 on.
    task automatic issue(input ins_t in, input int dhit_at, input logic [7:0] ihit_mask);
        logic        memop, served, dh, ih, stall;
        logic [31:0] ld;
        ctl_t        c;
        wb_t         w;
        int          cyc;
        memop  = (in.ren | in.wen) & !m_halt;
        served = 0;
        ld     = '0;
        cyc    = 0;
        while (1) begin
            ih = (cyc >= 8) ? 1'b1 : ihit_mask[cyc];
            dh = memop && !served && (cyc >= dhit_at);
            ihit = ih; dREN_in = in.ren; dWEN_in = in.wen; MemtoReg_in = in.m2r;
            RegWr_in = in.rw; jal_s_in = in.jal; lui_in = in.lui; halt_in = in.halt;
            wsel_in = in.wsel; alu_portOut_in = in.alu; rdat2_in = in.rdat2;
            pcplusfour_in = in.pc4; imm_addr_in = in.imm;
            dif.dhit = dh;
            dif.dmemload = memop ? $urandom : 32'h0;
            if (dh) ld = dif.dmemload;
            stall   = memop && !served && !dh;
            c.ren   = memop && !served && in.ren && !in.wen;
            c.wen   = memop && !served && in.wen;
            c.stall = stall;
            c.adv   = ih && !stall;
            c.addr  = in.alu;
            c.store = in.rdat2;
            ctl_q.push_back(c);
            if (c.adv) begin
                w.regwr = in.rw && !m_halt;
                w.wsel  = in.wsel;
                if (in.jal)                        w.wdat = in.pc4;
                else if (in.lui)                   w.wdat = {in.imm, 16'h0000};
                else if (in.m2r && !(in.ren && in.wen)) w.wdat = ld;
                else                               w.wdat = in.alu;
                m_halt = m_halt | in.halt;
                w.halt = m_halt;
                wb_q.push_back(w);
                @(posedge CLK); #1;
                break;
            end
            if (dh) served = 1;
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    // Monitor: request outputs are checked mid-cycle; after a cycle in which
    // the stage advanced, the MEM/WB register is checked the next mid-cycle.
    initial begin
        logic pend;
        ctl_t c;
        wb_t  w;
        pend = 0;
        forever begin
            @(negedge CLK);
            if (pend) begin
                pend = 0;
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_queue: advance with no expected entry");
                end else begin
                    w = wb_q.pop_front();
                    chk1("RegWr_out", RegWr_out, w.regwr);
                    chk32("wsel_out", 32'(wsel_out), 32'(w.wsel));
                    chk32("wdat_out", wdat_out, w.wdat);
                    chk1("halt_out", halt_out, w.halt);
                end
            end
            if (ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                chk1("dmemREN", dif.dmemREN, c.ren);
                chk1("dmemWEN", dif.dmemWEN, c.wen);
                chk1("mem_stall", mem_stall, c.stall);
                if (c.ren || c.wen) chk32("dmemaddr", dif.dmemaddr, c.addr);
                if (c.wen) chk32("dmemstore", dif.dmemstore, c.store);
                pend = c.adv;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t i;
        int   kind;
        clear_inputs();
        nRST = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        @(posedge CLK); #1;

        // Reset while a load is waiting on the cache.
        dREN_in = 1; MemtoReg_in = 1; RegWr_in = 1; alu_portOut_in = 32'h100; ihit = 1;
        #2;
        chk1("pre_reset_dmemREN", dif.dmemREN, 1'b1);
        chk1("pre_reset_stall", mem_stall, 1'b1);
        nRST = 0;
        #1;
        chk1("in_reset_dmemREN", dif.dmemREN, 1'b0);
        chk1("in_reset_stall", mem_stall, 1'b0);
        clear_inputs();
        @(posedge CLK); #1 nRST = 1;
        @(posedge CLK); #1;
        chk1("rst_RegWr_out", RegWr_out, 1'b0);
        chk32("rst_wsel_out", 32'(wsel_out), 32'h0);
        chk32("rst_wdat_out", wdat_out, 32'h0);
        chk1("rst_halt_out", halt_out, 1'b0);
        chk1("rst_dmemREN", dif.dmemREN, 1'b0);

        // ALU write.
        i = '{default: '0};
        i.rw = 1; i.wsel = 5'd8; i.alu = 32'h10;
        issue(i, 0, 8'hFF);
        // Load, cache answers on the third cycle.
        i = '{default: '0};
        i.ren = 1; i.m2r = 1; i.rw = 1; i.wsel = 5'd9; i.alu = 32'h100;
        issue(i, 2, 8'hFF);
        // Store completes while ihit is low for two more cycles.
        i = '{default: '0};
        i.wen = 1; i.alu = 32'h200; i.rdat2 = 32'hCAFE;
        issue(i, 0, 8'b1111_1000);
        // Load completes early, data must come from the parked copy.
        i = '{default: '0};
        i.ren = 1; i.m2r = 1; i.rw = 1; i.wsel = 5'd3; i.alu = 32'h104;
        issue(i, 1, 8'b1111_0000);
        // jal beats lui, then lui alone.
        i = '{default: '0};
        i.rw = 1; i.wsel = 5'd31; i.jal = 1; i.lui = 1; i.pc4 = 32'h44; i.imm = 16'h1234;
        issue(i, 0, 8'hFF);
        i.jal = 0;
        issue(i, 0, 8'hFF);
        // Illegal decode with MemtoReg: store, ALU value written back.
        i = '{default: '0};
        i.ren = 1; i.wen = 1; i.m2r = 1; i.rw = 1; i.wsel = 5'd4; i.alu = 32'h300; i.rdat2 = 32'h77;
        issue(i, 1, 8'hFF);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            i = '{default: '0};
            kind    = int'($urandom_range(0, 3));
            i.ren   = (kind == 1) || (kind == 3);
            i.wen   = (kind == 2) || (kind == 3);
            i.m2r   = (kind == 1) || ((kind == 3) && $urandom_range(0, 1) == 1);
            i.rw    = $urandom_range(0, 1) == 1;
            i.jal   = $urandom_range(0, 7) == 0;
            i.lui   = $urandom_range(0, 5) == 0;
            i.wsel  = 5'($urandom);
            i.alu   = $urandom;
            i.rdat2 = $urandom;
            i.pc4   = $urandom;
            i.imm   = 16'($urandom);
            issue(i, int'($urandom_range(0, 3)), 8'($urandom));
        end

        // Halt, then a store that must not reach the cache, then idle traffic.
        i = '{default: '0};
        i.halt = 1; i.alu = 32'h5;
        issue(i, 0, 8'hFF);
        i = '{default: '0};
        i.wen = 1; i.rw = 1; i.wsel = 5'd2; i.alu = 32'h400; i.rdat2 = 32'h99;
        issue(i, 0, 8'hFF);
        for (int n = 0; n < 10; n++) begin
            i = '{default: '0};
            i.rw = 1; i.wsel = 5'($urandom); i.alu = $urandom;
            issue(i, 0, 8'($urandom));
        end

        clear_inputs();
        repeat (3) @(posedge CLK);
        #1;
        chk32("ctl_queue_drained", 32'(ctl_q.size()), 32'h0);
        chk32("wb_queue_drained", 32'(wb_q.size()), 32'h0);
        chk1("halt_sticky_end", halt_out, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
